// File: rtl/parking_pkg.sv
// Shared types and segment codes for the multi-slot parking controller.
// Segment patterns are active-low, bit 6 = segment g.
package parking_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_WRONG = 3'd2,
    S_RIGHT = 3'd3,
    S_STOP  = 3'd4,
    S_LOCK  = 3'd5
  } state_e;

  localparam logic [6:0] HEX_OFF = 7'h7F;
  localparam logic [6:0] HEX_E   = 7'b000_0110;
  localparam logic [6:0] HEX_N   = 7'b010_1011;
  localparam logic [6:0] HEX_6   = 7'b000_0010;
  localparam logic [6:0] HEX_0   = 7'b100_0000;
  localparam logic [6:0] HEX_5   = 7'b001_0010;
  localparam logic [6:0] HEX_P   = 7'b000_1100;
  localparam logic [6:0] HEX_F   = 7'b000_1110;
  localparam logic [6:0] HEX_U   = 7'b100_0001;
  localparam logic [6:0] HEX_L   = 7'b100_0111;

endpackage

// File: rtl/parking_controller_multi_occupancy.sv
// Saturating up/down count of cars in the lot.
// Simultaneous inc and dec cancel out.
module parking_occupancy_counter #(
  parameter int CAPACITY = 8,
  parameter int CW       = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && count_q != CW'(CAPACITY)) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == CW'(CAPACITY));

endmodule

// File: rtl/parking_controller_multi.sv
// Password-gated entrance with lot occupancy tracking and lockout.
// LEDs and status digits are registered from the current state.
module parking_controller_multi
  import parking_pkg::*;
#(
  parameter int CAPACITY    = 8,
  parameter int PW_WIDTH    = 2,
  parameter int PASS_1      = 1,
  parameter int PASS_2      = 2,
  parameter int WAIT_CYCLES = 5,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sensor_entrance,
  input  logic                          sensor_exit,
  input  logic [PW_WIDTH-1:0]           password_1,
  input  logic [PW_WIDTH-1:0]           password_2,
  input  logic                          pass_valid,
  input  logic                          lot_exit,
  output logic                          GREEN_LED,
  output logic                          RED_LED,
  output logic [6:0]                    HEX_1,
  output logic [6:0]                    HEX_2,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy,
  output logic                          full,
  output logic                          locked
);

  localparam int OW = $clog2(CAPACITY + 1);
  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [TW-1:0] tries_q, tries_d;
  logic          green_q, green_d;
  logic          red_q, red_d;
  logic [6:0]    hex1_q, hex1_d;
  logic [6:0]    hex2_q, hex2_d;
  logic          match;
  logic          admit;
  logic [OW-1:0] occ;

  assign match = (password_1 == PW_WIDTH'(PASS_1))
              && (password_2 == PW_WIDTH'(PASS_2));

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    lock_d  = '0;
    tries_d = tries_q;
    admit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tries_d = '0;
        if (sensor_entrance && !full) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WW'(WAIT_CYCLES - 1)) begin
          if (match) begin
            state_d = S_RIGHT;
            tries_d = '0;
          end else begin
            tries_d = TW'(1);
            state_d = (MAX_TRIES == 1) ? S_LOCK : S_WRONG;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRONG: begin
        if (pass_valid) begin
          if (match) begin
            state_d = S_RIGHT;
            tries_d = '0;
          end else begin
            tries_d = tries_q + 1'b1;
            if (tries_d == TW'(MAX_TRIES)) state_d = S_LOCK;
          end
        end
      end
      S_LOCK: begin
        if (lock_q == LW'(LOCK_CYCLES - 1)) begin
          state_d = S_IDLE;
          tries_d = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      S_RIGHT: begin
        if (sensor_entrance && sensor_exit) begin
          state_d = S_STOP;
        end else if (sensor_exit) begin
          state_d = S_IDLE;
          tries_d = '0;
          admit   = 1'b1;
        end
      end
      S_STOP: begin
        if (!sensor_exit) state_d = S_WAIT;
      end
      default: begin
        state_d = S_IDLE;
        tries_d = '0;
      end
    endcase
  end

  // Indicator pattern for the state being left this cycle
  always_comb begin
    green_d = 1'b0;
    red_d   = 1'b0;
    hex1_d  = HEX_OFF;
    hex2_d  = HEX_OFF;
    case (state_q)
      S_IDLE: begin
        if (full) begin
          red_d  = 1'b1;
          hex1_d = HEX_F;
          hex2_d = HEX_U;
        end
      end
      S_WAIT: begin
        red_d  = 1'b1;
        hex1_d = HEX_E;
        hex2_d = HEX_N;
      end
      S_WRONG: begin
        red_d  = ~red_q;
        hex1_d = HEX_E;
        hex2_d = HEX_E;
      end
      S_RIGHT: begin
        green_d = ~green_q;
        hex1_d  = HEX_6;
        hex2_d  = HEX_0;
      end
      S_STOP: begin
        red_d  = ~red_q;
        hex1_d = HEX_5;
        hex2_d = HEX_P;
      end
      S_LOCK: begin
        red_d  = 1'b1;
        hex1_d = HEX_L;
        hex2_d = HEX_L;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      lock_q  <= '0;
      tries_q <= '0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
      hex1_q  <= HEX_OFF;
      hex2_q  <= HEX_OFF;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      lock_q  <= lock_d;
      tries_q <= tries_d;
      green_q <= green_d;
      red_q   <= red_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
    end
  end

  parking_occupancy_counter #(
    .CAPACITY(CAPACITY),
    .CW      (OW)
  ) u_occ (
    .clk  (clk),
    .rst_n(reset_n),
    .inc  (admit),
    .dec  (lot_exit),
    .count(occ),
    .full (full)
  );

  assign occupancy = occ;
  assign locked    = (state_q == S_LOCK);
  assign GREEN_LED = green_q;
  assign RED_LED   = red_q;
  assign HEX_1     = hex1_q;
  assign HEX_2     = hex2_q;

endmodule

// File: tb/tb_parking_controller_multi.sv
// Bench for parking_controller_multi: directed scenarios plus random
// traffic, all checked against an in-bench behavioural model.
module tb_parking_controller_multi;

  localparam int CAP   = 8;
  localparam int WAITC = 5;
  localparam int TRIES = 3;
  localparam int LOCKC = 16;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_WRONG = 2;
  localparam int M_RIGHT = 3;
  localparam int M_STOP  = 4;
  localparam int M_LOCK  = 5;

  localparam logic [6:0] G_OFF = 7'h7F;
  localparam logic [6:0] G_E   = 7'b000_0110;
  localparam logic [6:0] G_N   = 7'b010_1011;
  localparam logic [6:0] G_6   = 7'b000_0010;
  localparam logic [6:0] G_0   = 7'b100_0000;
  localparam logic [6:0] G_5   = 7'b001_0010;
  localparam logic [6:0] G_P   = 7'b000_1100;
  localparam logic [6:0] G_F   = 7'b000_1110;
  localparam logic [6:0] G_U   = 7'b100_0001;
  localparam logic [6:0] G_L   = 7'b100_0111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ent, ext, pv, le;
  logic [1:0] p1, p2;
  logic       green, red, full, locked;
  logic [6:0] hex1, hex2;
  logic [3:0] occupancy;

  int checks = 0;
  int errors = 0;

  int         m_st, m_wc, m_lc, m_tr, m_occ;
  logic       m_g, m_r;
  logic [6:0] m_h1, m_h2;

  always #5 clk = ~clk;

  parking_controller_multi #(
    .CAPACITY   (CAP),
    .PW_WIDTH   (2),
    .PASS_1     (1),
    .PASS_2     (2),
    .WAIT_CYCLES(WAITC),
    .MAX_TRIES  (TRIES),
    .LOCK_CYCLES(LOCKC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sensor_entrance(ent),
    .sensor_exit    (ext),
    .password_1     (p1),
    .password_2     (p2),
    .pass_valid     (pv),
    .lot_exit       (le),
    .GREEN_LED      (green),
    .RED_LED        (red),
    .HEX_1          (hex1),
    .HEX_2          (hex2),
    .occupancy      (occupancy),
    .full           (full),
    .locked         (locked)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st  = M_IDLE;
    m_wc  = 0;
    m_lc  = 0;
    m_tr  = 0;
    m_occ = 0;
    m_g   = 1'b0;
    m_r   = 1'b0;
    m_h1  = G_OFF;
    m_h2  = G_OFF;
  endtask

  // One clock edge of the lot, applied with the inputs the DUT sampled
  task automatic model_step();
    bit is_full, match, admit;
    int nst;
    is_full = (m_occ == CAP);
    match   = (p1 == 2'd1) && (p2 == 2'd2);
    admit   = 1'b0;
    nst     = m_st;
    case (m_st)
      M_IDLE:  begin m_g = 0; m_r = is_full;
                     m_h1 = is_full ? G_F : G_OFF;
                     m_h2 = is_full ? G_U : G_OFF; end
      M_WAIT:  begin m_g = 0; m_r = 1; m_h1 = G_E; m_h2 = G_N; end
      M_WRONG: begin m_g = 0; m_r = !m_r; m_h1 = G_E; m_h2 = G_E; end
      M_RIGHT: begin m_g = !m_g; m_r = 0; m_h1 = G_6; m_h2 = G_0; end
      M_STOP:  begin m_g = 0; m_r = !m_r; m_h1 = G_5; m_h2 = G_P; end
      default: begin m_g = 0; m_r = 1; m_h1 = G_L; m_h2 = G_L; end
    endcase
    case (m_st)
      M_IDLE: if (ent && !is_full) nst = M_WAIT;
      M_WAIT: begin
        if (m_wc == WAITC - 1) begin
          if (match) nst = M_RIGHT;
          else begin
            m_tr = 1;
            nst  = (TRIES == 1) ? M_LOCK : M_WRONG;
          end
        end
      end
      M_WRONG: begin
        if (pv) begin
          if (match) nst = M_RIGHT;
          else begin
            m_tr++;
            if (m_tr == TRIES) nst = M_LOCK;
          end
        end
      end
      M_RIGHT: begin
        if (ent && ext) nst = M_STOP;
        else if (ext) begin nst = M_IDLE; admit = 1; end
      end
      M_STOP: if (!ext) nst = M_WAIT;
      default: if (m_lc == LOCKC - 1) nst = M_IDLE;
    endcase
    m_wc = (m_st == M_WAIT && nst == M_WAIT) ? m_wc + 1 : 0;
    m_lc = (m_st == M_LOCK && nst == M_LOCK) ? m_lc + 1 : 0;
    if (nst == M_IDLE || nst == M_RIGHT) m_tr = 0;
    m_st = nst;
    if (admit && !le && m_occ < CAP) m_occ++;
    else if (le && !admit && m_occ > 0) m_occ--;
  endtask

  task automatic check_all();
    chk("green", 32'(green), 32'(m_g));
    chk("red", 32'(red), 32'(m_r));
    chk("hex1", 32'(hex1), 32'(m_h1));
    chk("hex2", 32'(hex2), 32'(m_h2));
    chk("occupancy", 32'(occupancy), 32'(m_occ));
    chk("full", 32'(full), 32'(m_occ == CAP));
    chk("locked", 32'(locked), 32'(m_st == M_LOCK));
  endtask

  task automatic cyc(input bit ie, input bit ix, input logic [1:0] ip1,
                     input logic [1:0] ip2, input bit ipv, input bit ile);
    ent = ie; ext = ix; p1 = ip1; p2 = ip2; pv = ipv; le = ile;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic enter_right();
    cyc(1, 0, 0, 0, 0, 0);
    repeat (WAITC) cyc(0, 0, 1, 2, 0, 0);
  endtask

  task automatic admit_car();
    enter_right();
    cyc(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    ent = 0; ext = 0; pv = 0; le = 0; p1 = 0; p2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hex1", 32'(hex1), 32'h7F);
    chk("rst_red", 32'(red), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    check_all();
    reset_n = 1'b1;

    // correct password entry
    cyc(1, 0, 0, 0, 0, 0);
    chk("pin_wait", m_st, M_WAIT);
    repeat (WAITC - 1) cyc(0, 0, 1, 2, 0, 0);
    chk("pin_wait_4", m_st, M_WAIT);
    cyc(0, 0, 1, 2, 0, 0);
    chk("pin_right", m_st, M_RIGHT);
    cyc(0, 0, 0, 0, 0, 0);
    chk("right_hex1", 32'(hex1), 32'(7'b000_0010));
    chk("right_hex2", 32'(hex2), 32'(7'b100_0000));
    cyc(0, 1, 0, 0, 0, 0);
    chk("admit_occ", 32'(occupancy), 32'd1);

    // lockout after three wrong attempts, entrance ignored
    cyc(1, 0, 0, 0, 0, 0);
    repeat (WAITC) cyc(0, 0, 0, 0, 0, 0);
    chk("pin_wrong", m_st, M_WRONG);
    chk("pin_tries1", m_tr, 1);
    cyc(0, 0, 3, 3, 1, 0);
    cyc(0, 0, 3, 3, 1, 0);
    chk("lock_now", 32'(locked), 32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("lock_red", 32'(red), 32'd1);
    chk("lock_hex", 32'(hex1), 32'(7'b100_0111));
    repeat (LOCKC - 2) cyc(1, 0, 0, 0, 0, 0);
    chk("lock_last", 32'(locked), 32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("lock_done", 32'(locked), 32'd0);
    chk("pin_tries0", m_tr, 0);
    idle(1);

    // recovery on the second attempt, then fresh failures to lock
    cyc(1, 0, 0, 0, 0, 0);
    repeat (WAITC) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 3, 3, 1, 0);
    cyc(0, 0, 1, 2, 1, 0);
    chk("pin_recover", m_st, M_RIGHT);
    cyc(0, 1, 0, 0, 0, 0);
    chk("occ2", 32'(occupancy), 32'd2);
    cyc(1, 0, 0, 0, 0, 0);
    repeat (WAITC) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 2, 2, 1, 0);
    chk("not_locked", 32'(locked), 32'd0);
    cyc(0, 0, 2, 2, 1, 0);
    chk("relock", 32'(locked), 32'd1);
    idle(LOCKC + 1);

    // fill the lot
    for (int i = 0; i < 20 && m_occ < CAP; i++) admit_car();
    chk("full_set", 32'(full), 32'd1);
    idle(1);
    chk("full_hex1", 32'(hex1), 32'(7'b000_1110));
    chk("full_hex2", 32'(hex2), 32'(7'b100_0001));
    cyc(1, 0, 0, 0, 0, 0);
    chk("pin_full_idle", m_st, M_IDLE);
    cyc(0, 0, 0, 0, 0, 1);
    chk("occ7", 32'(occupancy), 32'd7);
    chk("not_full", 32'(full), 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("pin_accept", m_st, M_WAIT);
    repeat (WAITC) cyc(0, 0, 1, 2, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);

    // boundaries: drain past zero, then admit with lot_exit together
    repeat (CAP + 1) cyc(0, 0, 0, 0, 0, 1);
    chk("occ_floor", 32'(occupancy), 32'd0);
    repeat (4) admit_car();
    enter_right();
    cyc(0, 1, 0, 0, 0, 1);
    chk("occ_cancel", 32'(occupancy), 32'd4);

    // STOP path and reset in the middle of STOP
    enter_right();
    cyc(1, 1, 0, 0, 0, 0);
    chk("pin_stop", m_st, M_STOP);
    repeat (3) cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pin_stop_wait", m_st, M_WAIT);
    chk("pin_stop_wc", m_wc, 0);
    repeat (WAITC) cyc(0, 0, 1, 2, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_green", 32'(green), 32'd0);
    chk("mid_rst_red", 32'(red), 32'd0);
    chk("mid_rst_hex1", 32'(hex1), 32'h7F);
    chk("mid_rst_hex2", 32'(hex2), 32'h7F);
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    model_reset();
    #2 reset_n = 1'b1;
    idle(1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] a, b;
      if ($urandom_range(0, 1) == 0) begin
        a = 2'd1; b = 2'd2;
      end else begin
        a = 2'($urandom_range(0, 3));
        b = 2'($urandom_range(0, 3));
      end
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, a, b,
          $urandom_range(0, 3) == 0,
          (m_st != M_LOCK) && ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
